// File: rtl/bram_pkg.sv
// Shared constants and byte-lane helpers for the dual-port byte-enable RAM.
package bram_pkg;

  // Read-during-write behaviour selectors
  localparam int unsigned RDW_READ_FIRST  = 0;
  localparam int unsigned RDW_WRITE_FIRST = 1;

  // Widest word the merge helper handles; callers zero-extend and truncate
  localparam int unsigned MAX_DATA_WIDTH = 1024;
  localparam int unsigned MAX_LANES      = MAX_DATA_WIDTH / 8;

  // Replace every byte of old_word whose lane enable is set with the byte from new_word
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_LANES-1:0]      lane_en
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    merged = old_word;
    for (int i = 0; i < int'(MAX_LANES); i++) begin
      if (lane_en[i]) merged[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dual_port_bram_be_if.sv
// Bus bundle for both access ports of the dual-port byte-enable RAM.
interface dual_port_bram_be_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);

  localparam int unsigned BE_WIDTH = DATA_WIDTH / 8;

  logic                  en0;
  logic                  en1;
  logic [BE_WIDTH-1:0]   we0;
  logic [BE_WIDTH-1:0]   we1;
  logic [ADDR_WIDTH-1:0] address0;
  logic [ADDR_WIDTH-1:0] address1;
  logic [DATA_WIDTH-1:0] data_in0;
  logic [DATA_WIDTH-1:0] data_in1;
  logic [DATA_WIDTH-1:0] data_out0;
  logic [DATA_WIDTH-1:0] data_out1;
  logic                  valid0;
  logic                  valid1;
  logic                  err0;
  logic                  err1;
  logic                  collision;

  modport master (
    output en0, en1, we0, we1, address0, address1, data_in0, data_in1,
    input  data_out0, data_out1, valid0, valid1, err0, err1, collision
  );

  modport slave (
    input  en0, en1, we0, we1, address0, address1, data_in0, data_in1,
    output data_out0, data_out1, valid0, valid1, err0, err1, collision
  );

endinterface

// File: rtl/bram_read_pipe.sv
// Read latency stages for one port: data, valid and err move together.
module bram_read_pipe #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  valid_i,
  input  logic                  err_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  valid_o,
  output logic                  err_o,
  output logic [DATA_WIDTH-1:0] data_o
);

  logic                  s1_valid_d, s1_valid_q;
  logic                  s1_err_d, s1_err_q;
  logic [DATA_WIDTH-1:0] s1_data_d, s1_data_q;

  // Stage 1 next state: data only moves on an accepted access, else it holds
  always_comb begin
    s1_valid_d = valid_i;
    s1_err_d   = valid_i & err_i;
    s1_data_d  = s1_data_q;
    if (valid_i) s1_data_d = err_i ? '0 : data_i;
  end

  // Stage 1 registers; reset drops anything in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_err_q   <= s1_err_d;
      s1_data_q  <= s1_data_d;
    end
  end

  if (READ_LATENCY >= 2) begin : g_stage2
    logic                  s2_valid_d, s2_valid_q;
    logic                  s2_err_d, s2_err_q;
    logic [DATA_WIDTH-1:0] s2_data_d, s2_data_q;

    // Stage 2 next state: follows stage 1, holding data between pulses
    always_comb begin
      s2_valid_d = s1_valid_q;
      s2_err_d   = s1_err_q;
      s2_data_d  = s2_data_q;
      if (s1_valid_q) s2_data_d = s1_data_q;
    end

    // Stage 2 registers
    always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
        s2_valid_q <= 1'b0;
        s2_err_q   <= 1'b0;
        s2_data_q  <= '0;
      end else begin
        s2_valid_q <= s2_valid_d;
        s2_err_q   <= s2_err_d;
        s2_data_q  <= s2_data_d;
      end
    end

    assign valid_o = s2_valid_q;
    assign err_o   = s2_err_q;
    assign data_o  = s2_data_q;
  end else begin : g_stage1_only
    assign valid_o = s1_valid_q;
    assign err_o   = s1_err_q;
    assign data_o  = s1_data_q;
  end

endmodule

// File: rtl/dual_port_bram_be.sv
// True dual-port RAM with byte write enables, selectable read-during-write
// behaviour, out-of-range detection and same-address write collision flag.
module dual_port_bram_be
  import bram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned ADDR_WIDTH   = $clog2(DEPTH),
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned RDW_MODE     = RDW_READ_FIRST,
  parameter string       INIT_FILE    = ""
) (
  input logic               clock,
  input logic               reset,
  dual_port_bram_be_if.slave bus
);

  localparam int unsigned BeWidth  = DATA_WIDTH / 8;
  localparam int unsigned IdxWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One extra bit so DEPTH itself is representable even when it is a power of two
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  acc0, acc1;
  logic                  in0, in1;
  logic                  oob0, oob1;
  logic                  wr0, wr1;
  logic                  same_addr;
  logic [IdxWidth-1:0]   idx0, idx1;
  logic [DATA_WIDTH-1:0] old0, old1;
  logic [DATA_WIDTH-1:0] post0, post1;
  logic [DATA_WIDTH-1:0] rd0, rd1;
  logic                  collision_d, collision_q;
  logic                  valid0, valid1, err0, err1;
  logic [DATA_WIDTH-1:0] data_out0, data_out1;

  function automatic logic [DATA_WIDTH-1:0] lane_merge(
    input logic [DATA_WIDTH-1:0] old_word,
    input logic [DATA_WIDTH-1:0] new_word,
    input logic [BeWidth-1:0]    be
  );
    return DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(old_word), MAX_DATA_WIDTH'(new_word),
                                  MAX_LANES'(be)));
  endfunction

  // Access decode, post-write word per port and read data selection
  always_comb begin
    // Nothing is accepted while reset is held low
    acc0      = bus.en0 & reset;
    acc1      = bus.en1 & reset;
    in0       = {1'b0, bus.address0} < DepthLim;
    in1       = {1'b0, bus.address1} < DepthLim;
    oob0      = ~in0;
    oob1      = ~in1;
    idx0      = bus.address0[IdxWidth-1:0];
    idx1      = bus.address1[IdxWidth-1:0];
    wr0       = acc0 & in0 & (|bus.we0);
    wr1       = acc1 & in1 & (|bus.we1);
    same_addr = (bus.address0 == bus.address1);

    old0 = in0 ? mem_q[idx0] : '0;
    old1 = in1 ? mem_q[idx1] : '0;

    // Port 1 lanes first, port 0 last, so port 0 wins lanes both enable
    post0 = old0;
    if (wr1 && same_addr) post0 = lane_merge(post0, bus.data_in1, bus.we1);
    if (wr0)              post0 = lane_merge(post0, bus.data_in0, bus.we0);
    post1 = old1;
    if (wr1)              post1 = lane_merge(post1, bus.data_in1, bus.we1);
    if (wr0 && same_addr) post1 = lane_merge(post1, bus.data_in0, bus.we0);

    if (RDW_MODE == RDW_WRITE_FIRST) begin
      rd0 = post0;
      rd1 = post1;
    end else begin
      rd0 = old0;
      rd1 = old1;
    end

    collision_d = wr0 & wr1 & same_addr;
  end

  // Array update; on a shared-address dual write both post words are identical
  always_ff @(posedge clock) begin
    if (wr0) mem_q[idx0] <= post0;
    if (wr1 && !(wr0 && same_addr)) mem_q[idx1] <= post1;
  end

  // Collision flag, pulsed the cycle after the dual write
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) collision_q <= 1'b0;
    else        collision_q <= collision_d;
  end

  bram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe0 (
    .clock  (clock),
    .reset  (reset),
    .valid_i(acc0),
    .err_i  (oob0),
    .data_i (rd0),
    .valid_o(valid0),
    .err_o  (err0),
    .data_o (data_out0)
  );

  bram_read_pipe #(
    .DATA_WIDTH  (DATA_WIDTH),
    .READ_LATENCY(READ_LATENCY)
  ) u_pipe1 (
    .clock  (clock),
    .reset  (reset),
    .valid_i(acc1),
    .err_i  (oob1),
    .data_i (rd1),
    .valid_o(valid1),
    .err_o  (err1),
    .data_o (data_out1)
  );

  assign bus.data_out0 = data_out0;
  assign bus.data_out1 = data_out1;
  assign bus.valid0    = valid0;
  assign bus.valid1    = valid1;
  assign bus.err0      = err0;
  assign bus.err1      = err1;
  assign bus.collision = collision_q;

endmodule

// File: tb/tb_dual_port_bram_be.sv
// Directed bench: three instances (read-first/1, write-first/1, read-first/2)
// share one stimulus stream; expected values are hand computed.
module tb_dual_port_bram_be;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 11;
  localparam int unsigned DEPTH = 1024;
  localparam int          NV    = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          en0, en1;
  logic [3:0]    we0, we1;
  logic [AW-1:0] a0, a1;
  logic [DW-1:0] d0, d1;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  dual_port_bram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_m0 ();
  dual_port_bram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_m1 ();
  dual_port_bram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus_l2 ();

  assign bus_m0.en0 = en0;      assign bus_m1.en0 = en0;      assign bus_l2.en0 = en0;
  assign bus_m0.en1 = en1;      assign bus_m1.en1 = en1;      assign bus_l2.en1 = en1;
  assign bus_m0.we0 = we0;      assign bus_m1.we0 = we0;      assign bus_l2.we0 = we0;
  assign bus_m0.we1 = we1;      assign bus_m1.we1 = we1;      assign bus_l2.we1 = we1;
  assign bus_m0.address0 = a0;  assign bus_m1.address0 = a0;  assign bus_l2.address0 = a0;
  assign bus_m0.address1 = a1;  assign bus_m1.address1 = a1;  assign bus_l2.address1 = a1;
  assign bus_m0.data_in0 = d0;  assign bus_m1.data_in0 = d0;  assign bus_l2.data_in0 = d0;
  assign bus_m0.data_in1 = d1;  assign bus_m1.data_in1 = d1;  assign bus_l2.data_in1 = d1;

  dual_port_bram_be #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(0),
    .INIT_FILE("")
  ) u_dut_m0 (.clock(clock), .reset(reset), .bus(bus_m0.slave));

  dual_port_bram_be #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1), .RDW_MODE(1),
    .INIT_FILE("")
  ) u_dut_m1 (.clock(clock), .reset(reset), .bus(bus_m1.slave));

  dual_port_bram_be #(
    .DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2), .RDW_MODE(0),
    .INIT_FILE("")
  ) u_dut_l2 (.clock(clock), .reset(reset), .bus(bus_l2.slave));

  // rf = read-first expectation, wf = write-first expectation
  typedef struct {
    logic          en0;
    logic [3:0]    we0;
    logic [AW-1:0] a0;
    logic [DW-1:0] d0;
    logic          en1;
    logic [3:0]    we1;
    logic [AW-1:0] a1;
    logic [DW-1:0] d1;
    logic          v0;
    logic [DW-1:0] q0_rf;
    logic [DW-1:0] q0_wf;
    logic          e0;
    logic          v1;
    logic [DW-1:0] q1_rf;
    logic [DW-1:0] q1_wf;
    logic          e1;
    logic          coll;
  } vec_t;

  vec_t          vecs [NV];
  logic [AW-1:0] seq_a [3];
  logic [DW-1:0] seq_q [3];

  task automatic chk1(input string nm, input int idx, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%b expected=%b", nm, idx, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input int idx, input logic [DW-1:0] act,
                      input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
    end
  endtask

  task automatic idle();
    en0 = 1'b0; we0 = 4'h0; a0 = '0; d0 = '0;
    en1 = 1'b0; we1 = 4'h0; a1 = '0; d1 = '0;
  endtask

  task automatic drive(input vec_t v);
    en0 = v.en0; we0 = v.we0; a0 = v.a0; d0 = v.d0;
    en1 = v.en1; we1 = v.we1; a1 = v.a1; d1 = v.d1;
  endtask

  task automatic access(input logic e0_i, input logic [3:0] w0_i, input logic [AW-1:0] ad0,
                        input logic [DW-1:0] dt0, input logic e1_i, input logic [3:0] w1_i,
                        input logic [AW-1:0] ad1, input logic [DW-1:0] dt1);
    @(negedge clock);
    en0 = e0_i; we0 = w0_i; a0 = ad0; d0 = dt0;
    en1 = e1_i; we1 = w1_i; a1 = ad1; d1 = dt1;
  endtask

  initial begin
    // Memory before the table: [0]=01020304 [5]=0 [7]=11223344 [9]=0
    // Held outputs before the table: port0=11223344, port1=00000000
    vecs[0]  = '{1'b1, 4'hF, 11'd5, 32'hDEADBEEF, 1'b0, 4'h0, 11'd0, 32'h0,
                 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 4'h0, 11'd0, 32'h0, 1'b1, 4'h0, 11'd5, 32'h0,
                 1'b0, 32'h0, 32'hDEADBEEF, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 4'h3, 11'd7, 32'hAABBCCDD, 1'b0, 4'h0, 11'd0, 32'h0,
                 1'b1, 32'h11223344, 32'h1122CCDD, 1'b0,
                 1'b0, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 4'h3, 11'd9, 32'h0000AAAA, 1'b1, 4'h6, 11'd9, 32'h00BBBB00,
                 1'b1, 32'h0, 32'h00BBAAAA, 1'b0, 1'b1, 32'h0, 32'h00BBAAAA, 1'b0, 1'b1};
    vecs[4]  = '{1'b1, 4'h0, 11'd9, 32'h0, 1'b1, 4'h0, 11'd1024, 32'h0,
                 1'b1, 32'h00BBAAAA, 32'h00BBAAAA, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 4'h0, 11'd0, 32'h0, 1'b1, 4'hF, 11'd1024, 32'hCAFEF00D,
                 1'b1, 32'h01020304, 32'h01020304, 1'b0, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 4'h0, 11'd0, 32'h0, 1'b1, 4'h0, 11'd7, 32'h0,
                 1'b1, 32'h01020304, 32'h01020304, 1'b0,
                 1'b1, 32'h1122CCDD, 32'h1122CCDD, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 4'h0, 11'd5, 32'h0, 1'b1, 4'hC, 11'd5, 32'h12340000,
                 1'b1, 32'hDEADBEEF, 32'h1234BEEF, 1'b0,
                 1'b1, 32'hDEADBEEF, 32'h1234BEEF, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 4'h0, 11'd5, 32'h0, 1'b1, 4'h0, 11'd9, 32'h0,
                 1'b1, 32'h1234BEEF, 32'h1234BEEF, 1'b0,
                 1'b1, 32'h00BBAAAA, 32'h00BBAAAA, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 4'hF, 11'd5, 32'h0, 1'b0, 4'hF, 11'd9, 32'h0,
                 1'b0, 32'h1234BEEF, 32'h1234BEEF, 1'b0,
                 1'b0, 32'h00BBAAAA, 32'h00BBAAAA, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 4'h0, 11'd5, 32'h0, 1'b1, 4'h0, 11'd9, 32'h0,
                 1'b1, 32'h1234BEEF, 32'h1234BEEF, 1'b0,
                 1'b1, 32'h00BBAAAA, 32'h00BBAAAA, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 4'h0, 11'd9, 32'h0, 1'b1, 4'hF, 11'd9, 32'h55555555,
                 1'b1, 32'h00BBAAAA, 32'h55555555, 1'b0,
                 1'b1, 32'h00BBAAAA, 32'h55555555, 1'b0, 1'b0};
    seq_a[0] = 11'd7;        seq_a[1] = 11'd9;        seq_a[2] = 11'd0;
    seq_q[0] = 32'h1122CCDD; seq_q[1] = 32'h55555555; seq_q[2] = 32'h01020304;

    // Reset state
    idle();
    reset = 1'b1;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk1("rst_valid0", 0, bus_l2.valid0, 1'b0);
    chk1("rst_valid1", 0, bus_m0.valid1, 1'b0);
    chkw("rst_data0", 0, bus_l2.data_out0, 32'h0);
    chkw("rst_data1", 0, bus_m1.data_out1, 32'h0);
    chk1("rst_err1", 0, bus_m0.err1, 1'b0);
    chk1("rst_coll", 0, bus_m0.collision, 1'b0);
    @(negedge clock);
    reset = 1'b1;

    // Known contents and known held outputs
    access(1'b1, 4'hF, 11'd5, 32'h0, 1'b1, 4'hF, 11'd7, 32'h11223344);
    access(1'b1, 4'hF, 11'd9, 32'h0, 1'b1, 4'hF, 11'd0, 32'h01020304);
    access(1'b1, 4'h0, 11'd7, 32'h0, 1'b1, 4'h0, 11'd9, 32'h0);
    @(negedge clock);
    idle();
    repeat (3) @(posedge clock);

    // Table: one access, one idle cycle, latency-1 then latency-2 checks
    for (int k = 0; k < NV; k++) begin
      @(negedge clock);
      drive(vecs[k]);
      @(posedge clock);
      #1;
      chk1("m0_valid0", k, bus_m0.valid0, vecs[k].v0);
      chkw("m0_data0", k, bus_m0.data_out0, vecs[k].q0_rf);
      chk1("m0_err0", k, bus_m0.err0, vecs[k].e0);
      chk1("m0_valid1", k, bus_m0.valid1, vecs[k].v1);
      chkw("m0_data1", k, bus_m0.data_out1, vecs[k].q1_rf);
      chk1("m0_err1", k, bus_m0.err1, vecs[k].e1);
      chk1("m0_coll", k, bus_m0.collision, vecs[k].coll);
      chk1("m1_valid0", k, bus_m1.valid0, vecs[k].v0);
      chkw("m1_data0", k, bus_m1.data_out0, vecs[k].q0_wf);
      chkw("m1_data1", k, bus_m1.data_out1, vecs[k].q1_wf);
      chk1("m1_err1", k, bus_m1.err1, vecs[k].e1);
      chk1("m1_coll", k, bus_m1.collision, vecs[k].coll);
      chk1("l2_coll", k, bus_l2.collision, vecs[k].coll);
      chk1("l2_early_valid0", k, bus_l2.valid0, 1'b0);
      chk1("l2_early_valid1", k, bus_l2.valid1, 1'b0);
      @(negedge clock);
      idle();
      @(posedge clock);
      #1;
      chk1("l2_valid0", k, bus_l2.valid0, vecs[k].v0);
      chkw("l2_data0", k, bus_l2.data_out0, vecs[k].q0_rf);
      chk1("l2_err0", k, bus_l2.err0, vecs[k].e0);
      chk1("l2_valid1", k, bus_l2.valid1, vecs[k].v1);
      chkw("l2_data1", k, bus_l2.data_out1, vecs[k].q1_rf);
      chk1("l2_err1", k, bus_l2.err1, vecs[k].e1);
      chk1("m0_pulse_end0", k, bus_m0.valid0, 1'b0);
      chk1("m0_coll_end", k, bus_m0.collision, 1'b0);
    end

    // Back-to-back reads on port 0: one valid per cycle at both latencies
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      idle();
      if (c < 3) begin
        en0 = 1'b1;
        a0  = seq_a[c];
      end
      @(posedge clock);
      #1;
      chk1("b2b_m0_valid", c, bus_m0.valid0, c < 3);
      if (c < 3) chkw("b2b_m0_data", c, bus_m0.data_out0, seq_q[c]);
      chk1("b2b_l2_valid", c, bus_l2.valid0, (c >= 1) && (c < 4));
      if ((c >= 1) && (c < 4)) chkw("b2b_l2_data", c, bus_l2.data_out0, seq_q[c-1]);
    end

    // Reset mid-stream: in-flight reads dropped, writes under reset ignored
    access(1'b1, 4'h0, 11'd7, 32'h0, 1'b1, 4'h0, 11'd0, 32'h0);
    @(posedge clock);
    #1;
    chk1("pre_rst_valid0", 0, bus_m0.valid0, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk1("mid_rst_l2_valid0", 0, bus_l2.valid0, 1'b0);
    chk1("mid_rst_l2_valid1", 0, bus_l2.valid1, 1'b0);
    chkw("mid_rst_l2_data0", 0, bus_l2.data_out0, 32'h0);
    chkw("mid_rst_l2_data1", 0, bus_l2.data_out1, 32'h0);
    chkw("mid_rst_m0_data0", 0, bus_m0.data_out0, 32'h0);
    chk1("mid_rst_m0_valid0", 0, bus_m0.valid0, 1'b0);
    chkw("mid_rst_m1_data1", 0, bus_m1.data_out1, 32'h0);
    en0 = 1'b1; we0 = 4'hF; a0 = 11'd7; d0 = 32'hFFFFFFFF;
    en1 = 1'b1; we1 = 4'hF; a1 = 11'd0; d1 = 32'hFFFFFFFF;
    repeat (2) @(posedge clock);
    #1;
    chk1("in_rst_l2_valid0", 0, bus_l2.valid0, 1'b0);
    @(negedge clock);
    idle();
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock);
      #1;
      chk1("post_rst_l2_valid0", c, bus_l2.valid0, 1'b0);
      chk1("post_rst_l2_valid1", c, bus_l2.valid1, 1'b0);
      chk1("post_rst_m0_valid0", c, bus_m0.valid0, 1'b0);
      chk1("post_rst_m1_valid1", c, bus_m1.valid1, 1'b0);
    end
    access(1'b1, 4'h0, 11'd7, 32'h0, 1'b1, 4'h0, 11'd0, 32'h0);
    @(posedge clock);
    #1;
    chkw("kept_m0_data0", 0, bus_m0.data_out0, 32'h1122CCDD);
    chkw("kept_m0_data1", 0, bus_m0.data_out1, 32'h01020304);
    @(negedge clock);
    idle();
    @(posedge clock);
    #1;
    chk1("kept_l2_valid0", 0, bus_l2.valid0, 1'b1);
    chkw("kept_l2_data0", 0, bus_l2.data_out0, 32'h1122CCDD);
    chkw("kept_l2_data1", 0, bus_l2.data_out1, 32'h01020304);

    repeat (2) @(posedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dual_port_bram_be.md
DUAL_PORT_BRAM_BE -- requirements
Module: dual_port_bram_be

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits (multiple of 8).
REQ-002 SHALL have parameter DEPTH, default 1024, number of words.
REQ-003 SHALL have parameter ADDR_WIDTH, default $clog2(DEPTH), address bits per port.
REQ-004 SHALL have parameter READ_LATENCY, default 1, clocks from accepted read to valid data (legal values 1, 2).
REQ-005 SHALL have parameter RDW_MODE, default 0, read-during-write mode: 0 read-first, 1 write-first.
REQ-006 SHALL have parameter INIT_FILE, default "", hex image loaded at elaboration; empty string means no load.
REQ-007 SHALL have ports: clock  in  1  single clock, all logic on rising edge.
REQ-008 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-009 SHALL have ports: en0, en1  in  1  port access enable.
REQ-010 SHALL have ports: we0, we1  in  DATA_WIDTH/8  byte write enables, used only when enN=1.
REQ-011 SHALL have ports: address0, address1  in  ADDR_WIDTH  word address.
REQ-012 SHALL have ports: data_in0, data_in1  in  DATA_WIDTH  write data.
REQ-013 SHALL have ports: data_out0, data_out1  out  DATA_WIDTH  read data.
REQ-014 SHALL have ports: valid0, valid1  out  1  one-cycle pulse, data_outN is new.
REQ-015 SHALL have ports: err0, err1  out  1  one-cycle pulse aligned to validN, address was >= DEPTH.
REQ-016 SHALL have ports: collision  out  1  one-cycle pulse, both ports wrote the same address in the same cycle.

Function
REQ-017 Each access with enN=1 SHALL be a read; SHALL also write every byte lane i with weN[i]=1.
REQ-018 validN SHALL assert exactly READ_LATENCY cycles after the accepting edge; back-to-back accesses SHALL give back-to-back valids (throughput 1/cycle/port).
REQ-019 data_outN SHALL hold its last value while validN=0.
REQ-020 Same-port read-during-write: RDW_MODE=0 SHALL return pre-write word; RDW_MODE=1 SHALL return post-write word (unwritten lanes old).
REQ-021 Cross-port same address, one writes, other reads: reader SHALL see old word (mode 0) or merged new word (mode 1).
REQ-022 Both ports write same address: lanes enabled on both SHALL take port 0 data; lanes on one port only SHALL take that port's data; collision SHALL pulse one cycle later.
REQ-023 In mode 1, a dual write to the same address SHALL return the final merged word on both ports.
REQ-024 Address >= DEPTH SHALL suppress the write, return zero data, and pulse errN with validN.
REQ-025 READ_LATENCY=2 SHALL add one output register stage; data, valid and err SHALL travel together.

Reset
REQ-026 reset low SHALL asynchronously clear data_out0/1, valid0/1, err0/1, collision and all pipeline stages to 0.
REQ-027 Memory array contents SHALL NOT be cleared by reset; accesses during reset SHALL be ignored (no write).
REQ-028 Reads in flight at reset assertion SHALL be dropped; no valid SHALL appear after release for them.

Structure
REQ-029 Package bram_pkg SHALL hold RDW_READ_FIRST/RDW_WRITE_FIRST constants and the byte-merge function.
REQ-030 Sub-module bram_read_pipe SHALL implement one port's latency stages (data, valid, err), instantiated twice.

Verification
REQ-031 Write 0xDEADBEEF to addr 5 port 0, we=4'hF; next read addr 5 port 1 -> data_out1=0xDEADBEEF, valid1 after READ_LATENCY.
REQ-032 Addr 7 holds 0x11223344; port 0 writes 0xAABBCCDD we=4'b0011 with read -> mode 0 returns 0x11223344, mode 1 returns 0x1122CCDD.
REQ-033 Same cycle addr 9: port 0 we=4'b0011 data 0x000000AA-style 0x0000AAAA, port 1 we=4'b0110 data 0x00BBBB00 -> addr 9=0x00BBAAAA, collision=1 one cycle.
REQ-034 Read addr DEPTH (1024) on port 1 -> data_out1=0, err1=1 with valid1; array unchanged.
REQ-035 READ_LATENCY=2, reads issued every cycle, reset pulsed low mid-stream -> outputs 0 immediately, no stale valid after release, array preserved.
